// File: rtl/reflet_mem_bridge_if.sv
// rtl/reflet_mem_bridge_if.sv - req/ack word-memory bus between the bridge and external memory
//
// Purpose: groups the external memory handshake into one bundle.
// Ports (signals):
//   mem_req    request, held until mem_ack is sampled
//   mem_we     1 = write, 0 = read; valid while mem_req is high
//   mem_addr   word address
//   mem_wdata  write data
//   mem_rdata  read data, valid with mem_ack on a read
//   mem_ack    one-cycle completion pulse
// Modports: master = bridge side, slave = memory side.
interface reflet_mem_bridge_if #(
    parameter int wordsize = 16
);
    logic                mem_req;
    logic                mem_we;
    logic [wordsize-1:0] mem_addr;
    logic [wordsize-1:0] mem_wdata;
    logic [wordsize-1:0] mem_rdata;
    logic                mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/reflet_mem_bridge.sv
// rtl/reflet_mem_bridge.sv - CPU RAM-port responder over a slow req/ack word memory
//
// Purpose: serves the CPU address unit's RAM port from an external word memory,
// stalling the CPU via cpu_enable while an access is outstanding, and keeps a
// one-word read buffer so repeated reads of the same word cost no wait cycles.
// Ports:
//   clk           clock
//   reset         synchronous, active-low reset
//   cpu_addr      byte address from the CPU
//   cpu_data_out  full word to write (byte merging done by the CPU)
//   cpu_write_en  write strobe, held while the CPU is stalled
//   cpu_data_in   word containing cpu_addr (buffer contents)
//   cpu_enable    CPU clock enable
//   mem           external memory bus (master side)
//   bus_error     one-cycle pulse when an access times out
module reflet_mem_bridge #(
    parameter int wordsize = 16,
    parameter int timeout  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [wordsize-1:0]        cpu_addr,
    input  logic [wordsize-1:0]        cpu_data_out,
    input  logic                       cpu_write_en,
    output logic [wordsize-1:0]        cpu_data_in,
    output logic                       cpu_enable,
    reflet_mem_bridge_if.master        mem,
    output logic                       bus_error
);
    localparam int byte_bits = $clog2(wordsize / 8);
    localparam int cnt_w     = (timeout > 1) ? $clog2(timeout) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [wordsize-1:0] word_index;
    logic [wordsize-1:0] buf_tag;
    logic                buf_valid;
    logic                wr_done;
    logic                hit;
    logic                timed_out;
    logic [cnt_w-1:0]    tcnt;

    assign word_index = cpu_addr >> byte_bits;
    assign hit        = buf_valid && (word_index == buf_tag);

    // An ack in the same cycle wins over the timeout; callers test mem_ack first.
    assign timed_out  = (timeout != 0) && (tcnt == cnt_w'(timeout - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a pending write takes priority over a read miss.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_write_en) begin
                    if (!wr_done) begin
                        state_nxt = WRITE;
                    end
                end else if (!hit) begin
                    state_nxt = READ;
                end
            end
            READ, WRITE: begin
                if (mem.mem_ack || timed_out) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the CPU only advances from IDLE once its access is satisfied.
    always_comb begin
        cpu_enable = 1'b0;
        if (state == IDLE) begin
            cpu_enable = cpu_write_en ? wr_done : hit;
        end
    end

    // Datapath registers: request, buffer, write-done flag and timeout counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            cpu_data_in   <= '0;
            buf_tag       <= '0;
            buf_valid     <= 1'b0;
            wr_done       <= 1'b0;
            bus_error     <= 1'b0;
            tcnt          <= '0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    // Counter is parked at zero so every access starts fresh.
                    tcnt <= '0;
                    if (cpu_write_en) begin
                        if (wr_done) begin
                            // CPU consumes the finished write this cycle.
                            wr_done <= 1'b0;
                        end else begin
                            mem.mem_addr  <= word_index;
                            mem.mem_wdata <= cpu_data_out;
                            mem.mem_we    <= 1'b1;
                            mem.mem_req   <= 1'b1;
                        end
                    end else if (!hit) begin
                        mem.mem_addr <= word_index;
                        mem.mem_we   <= 1'b0;
                        mem.mem_req  <= 1'b1;
                    end
                end
                READ: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        buf_tag     <= mem.mem_addr;
                        buf_valid   <= 1'b1;
                        cpu_data_in <= mem.mem_rdata;
                    end else if (timed_out) begin
                        // Aborted read returns all ones and is cached so the
                        // CPU is not stuck re-fetching a dead address.
                        mem.mem_req <= 1'b0;
                        bus_error   <= 1'b1;
                        buf_tag     <= mem.mem_addr;
                        buf_valid   <= 1'b1;
                        cpu_data_in <= '1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (mem.mem_ack || timed_out) begin
                        mem.mem_req <= 1'b0;
                        wr_done     <= 1'b1;
                        bus_error   <= !mem.mem_ack;
                        // Keep the buffer coherent with a successful write to its word.
                        if (mem.mem_ack && buf_valid && (mem.mem_addr == buf_tag)) begin
                            cpu_data_in <= mem.mem_wdata;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    mem.mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reflet_mem_bridge.sv
// tb/tb_reflet_mem_bridge.sv - scoreboard testbench for reflet_mem_bridge
module tb_reflet_mem_bridge;
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } beat_t;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_data_out;
    logic        cpu_write_en;
    logic [15:0] cpu_data_in;
    logic        cpu_enable;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    // Memory model state (written only by the model process)
    logic [15:0] mem [0:255];
    int          cyc = 0;
    int          mcnt = 0;
    logic        req_prev = 1'b0;
    int          req_count = 0;
    int          req_rise_cyc = 0;
    int          berr_count = 0;
    int          berr_cyc = 0;
    logic        berr_req = 1'b0;
    int          obs_n = 0;
    logic        obs_we [0:63];
    logic [15:0] obs_addr [0:63];
    logic [15:0] obs_wdata [0:63];
    int          stray_done = 0;

    // Stimulus-side state (written only by the main process)
    int          lat = 3;
    int          stray_req = 0;
    int          seen = 0;
    logic [15:0] rd_q [$];
    beat_t       beat_q [$];

    reflet_mem_bridge_if #(.wordsize(16)) mif ();

    reflet_mem_bridge #(.wordsize(16), .timeout(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_write_en (cpu_write_en),
        .cpu_data_in  (cpu_data_in),
        .cpu_enable   (cpu_enable),
        .mem          (mif),
        .bus_error    (bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [15:0] init_val(input int i);
        logic [15:0] v;
        v = 16'(i * 16'h0101) ^ 16'hA5A5;
        if (i == 0) v = 16'h1234;
        if (i == 8) v = 16'h5678;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // External memory: acks after lat cycles of mem_req (lat==0 never acks).
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            #2;
            if (mif.mem_req && !req_prev) begin
                req_count++;
                req_rise_cyc = cyc;
            end
            req_prev = mif.mem_req;
            if (bus_error) begin
                berr_count++;
                berr_cyc = cyc;
                berr_req = mif.mem_req;
            end
            mif.mem_ack = 1'b0;
            if (stray_req != stray_done) begin
                mif.mem_ack = 1'b1;
                stray_done  = stray_req;
            end else if (mif.mem_req) begin
                mcnt++;
                if (lat != 0 && mcnt == lat) begin
                    mif.mem_ack = 1'b1;
                    if (obs_n < 64) begin
                        obs_we[obs_n]    = mif.mem_we;
                        obs_addr[obs_n]  = mif.mem_addr;
                        obs_wdata[obs_n] = mif.mem_wdata;
                        obs_n++;
                    end
                    if (mif.mem_we) mem[mif.mem_addr[7:0]] = mif.mem_wdata;
                    else            mif.mem_rdata = mem[mif.mem_addr[7:0]];
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // One CPU access: call at a negedge; returns at the negedge after the CPU consumes it.
    task automatic cpu_access(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] exp_rd, input int exp_stall, input bit beat);
        int          n;
        logic [15:0] e;
        beat_t       b;
        cpu_write_en = we;
        cpu_addr     = addr;
        cpu_data_out = wdata;
        rd_q.push_back(exp_rd);
        if (beat) begin
            b.we   = we;
            b.addr = addr >> 1;
            b.data = wdata;
            beat_q.push_back(b);
        end
        n = 0;
        forever begin
            #1;
            if (cpu_enable || n >= 40) break;
            @(negedge clk);
            n++;
        end
        check("stall", n, exp_stall);
        e = rd_q.pop_front();
        check("cpu_data_in", cpu_data_in, e);
        while (seen < obs_n) begin
            if (beat_q.size() == 0) begin
                check("beat_pending", 32'(beat_q.size()), 32'd1);
            end else begin
                b = beat_q.pop_front();
                check("beat_we", obs_we[seen], b.we);
                check("beat_addr", obs_addr[seen], b.addr);
                if (b.we) check("beat_wdata", obs_wdata[seen], b.data);
            end
            seen++;
        end
        if (beat_q.size() != 0) begin
            check("beat_missing", 32'(beat_q.size()), 32'd0);
            beat_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int b0;
        reset        = 1'b0;
        cpu_addr     = 16'h0000;
        cpu_data_out = 16'h0000;
        cpu_write_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_enable", cpu_enable, 1'b0);
        check("rst_req", mif.mem_req, 1'b0);
        check("rst_we", mif.mem_we, 1'b0);
        check("rst_addr", mif.mem_addr, 16'h0);
        check("rst_wdata", mif.mem_wdata, 16'h0);
        check("rst_data", cpu_data_in, 16'h0);
        check("rst_berr", bus_error, 1'b0);

        // First cycle after reset is a miss on word 0
        @(negedge clk);
        reset = 1'b1;
        cpu_access(0, 16'h0000, 16'h0, 16'h1234, 4, 1);

        // Miss on word 8, then same word via another byte address hits
        cpu_access(0, 16'h0010, 16'h0, 16'h5678, 4, 1);
        r0 = req_count;
        cpu_access(0, 16'h0011, 16'h0, 16'h5678, 0, 0);
        #3;
        check("hit_noreq", req_count - r0, 0);

        // Write to the buffered word: one beat, buffer updated, no re-read
        r0 = req_count;
        cpu_access(1, 16'h0010, 16'hBEEF, 16'hBEEF, 4, 1);
        #1;
        check("wr_once", cpu_enable, 1'b0);
        cpu_write_en = 1'b0;
        cpu_access(0, 16'h0010, 16'h0, 16'hBEEF, 0, 0);
        #3;
        check("wr_noreread", req_count - r0, 1);

        // Write to another word leaves the buffer alone
        r0 = req_count;
        cpu_access(1, 16'h0012, 16'h1357, 16'hBEEF, 4, 1);
        #1;
        check("wr9_once", cpu_enable, 1'b0);
        cpu_write_en = 1'b0;
        cpu_access(0, 16'h0010, 16'h0, 16'hBEEF, 0, 0);
        #3;
        check("wr9_hit_noreq", req_count - r0, 1);
        cpu_access(0, 16'h0012, 16'h0, 16'h1357, 4, 1);

        // Ack in the same cycle as the timeout counts as success
        b0  = berr_count;
        lat = 4;
        cpu_access(0, 16'h000C, 16'h0, init_val(6), 5, 1);
        #3;
        check("ack_at_timeout", berr_count - b0, 0);

        // Read timeout on word 5
        b0  = berr_count;
        lat = 0;
        cpu_access(0, 16'h000A, 16'h0, 16'hFFFF, 5, 0);
        #3;
        check("rd_berr_count", berr_count - b0, 1);
        check("rd_berr_delay", berr_cyc - req_rise_cyc, 4);
        check("rd_berr_req", berr_req, 1'b0);
        r0 = req_count;
        cpu_access(0, 16'h000A, 16'h0, 16'hFFFF, 0, 0);
        #3;
        check("to_hit_noreq", req_count - r0, 0);

        // Write timeout discards the write
        b0 = berr_count;
        cpu_access(1, 16'h0014, 16'hAAAA, 16'hFFFF, 5, 0);
        #1;
        check("wrto_once", cpu_enable, 1'b0);
        check("wr_berr_count", berr_count - b0, 1);
        cpu_write_en = 1'b0;
        lat = 2;
        cpu_access(0, 16'h0014, 16'h0, init_val(10), 3, 1);

        // Reset mid-read, stray ack after release, fresh fetch
        lat      = 0;
        cpu_addr = 16'h0020;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_req", mif.mem_req, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_req", mif.mem_req, 1'b0);
        check("mid_rst_enable", cpu_enable, 1'b0);
        check("mid_rst_data", cpu_data_in, 16'h0);
        @(negedge clk);
        reset     = 1'b1;
        stray_req = stray_req + 1;
        lat       = 2;
        cpu_access(0, 16'h0020, 16'h0, init_val(16), 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reflet_mem_bridge.md
Name: reflet_mem_bridge

Overview:
- Memory-side responder for the CPU address unit's RAM port: `addr`, `data_out`, `write_en`, `data_in`.
- Serves that port from a slower external word memory that uses a req/ack handshake.
- Stalls the CPU through its `enable` input while an access is outstanding.
- Holds a one-word read buffer so that repeated reads of the same word cost no wait cycles.

Parameters:
- wordsize, 16, data/address width in bits; multiple of 8, at least 16.
- timeout, 64, cycles to wait for `mem_ack` before aborting the access; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- cpu_addr  in  wordsize  byte address from the CPU
- cpu_data_out  in  wordsize  full word to write; byte merging is already done by the CPU
- cpu_write_en  in  1  write strobe; held high while the CPU is stalled
- cpu_data_in  out  wordsize  word containing cpu_addr
- cpu_enable  out  1  CPU clock enable
- mem_req  out  1  external access request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
- mem_addr  out  wordsize  word address, equal to cpu_addr >> log2(wordsize/8)
- mem_wdata  out  wordsize  write data
- mem_rdata  in  wordsize  read data; valid when mem_ack is high on a read
- mem_ack  in  1  one-cycle completion pulse
- bus_error  out  1  one-cycle pulse when an access times out

Behaviour:
- Widths and tags:
  - word index = cpu_addr >> log2(wordsize/8); low byte bits are ignored.
  - tag = word index; hit = buf_valid && tag == buf_tag.
- Reset (reset==0):
  - State goes to IDLE; buf_valid=0, wr_done=0.
  - Outputs: cpu_data_in=0, cpu_enable=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_error=0.
  - Reset mid-access drops mem_req immediately; a later mem_ack is ignored.
- States: IDLE, READ, WRITE.
- cpu_enable is combinational: 1 only in IDLE when either
  - cpu_write_en==1 and wr_done==1, or
  - cpu_write_en==0 and hit==1.
- IDLE transitions (write has priority over read miss):
  - cpu_write_en==1 and wr_done==0: go to WRITE; register mem_addr=word index, mem_wdata=cpu_data_out, mem_we=1, mem_req=1.
  - cpu_write_en==1 and wr_done==1: the CPU consumes the write this cycle; clear wr_done next cycle.
  - cpu_write_en==0 and miss: go to READ; register mem_addr, mem_we=0, mem_req=1.
- mem_req protocol:
  - Stays high, with addr/data/we stable, until the cycle in which mem_ack==1 is sampled.
  - Drops on the following edge.
  - A new request is issued no earlier than one cycle after the ack.
- READ completes on mem_ack:
  - buf_tag=mem_addr, cpu_data_in=mem_rdata, buf_valid=1, return to IDLE.
  - cpu_enable rises one cycle after the ack edge.
  - Miss latency is 1 + memory latency + 1 cycles.
- WRITE completes on mem_ack:
  - wr_done=1, return to IDLE.
  - If mem_addr==buf_tag and buf_valid, set cpu_data_in=mem_wdata; the buffer stays coherent and no re-read occurs.
  - Otherwise the buffer is unchanged.
- Timeout counter:
  - Cleared on entering READ/WRITE and counts each cycle while mem_req is high.
  - When timeout!=0 and the counter reaches timeout-1 with no ack: pulse bus_error for 1 cycle, drop mem_req, return to IDLE.
  - Read timeout: cpu_data_in = all ones, buffer tagged valid for that word.
  - Write timeout: wr_done=1; the write is discarded.
- Simultaneous events:
  - A mem_ack in the same cycle the timeout fires counts as success; bus_error is not raised.
  - mem_ack while in IDLE is ignored.
- Address wrap: the index is derived purely by shift, so no wrap handling is required; the maximum address maps to the last word.
- After reset release the first cycle is a miss (buf_valid=0), so the bridge fetches the word at cpu_addr.

Test Plan:
- Reset release with cpu_addr=0x0000 and memory word 0 = 0x1234, ack after 3 cycles -> mem_req high with mem_addr=0 and mem_we=0; cpu_enable=0 until the cycle after ack; then cpu_data_in=0x1234 and cpu_enable=1.
- cpu_addr changes 0x0010 -> 0x0011 (wordsize=16, same word index 8) -> no new mem_req; cpu_enable stays 1.
- cpu_write_en=1, cpu_addr=0x0010, cpu_data_out=0xBEEF, word 8 buffered -> exactly one write beat with mem_addr=8 and mem_wdata=0xBEEF; cpu_enable=1 for exactly one cycle after ack; cpu_data_in=0xBEEF; no read follows.
- Write to word 9 while word 8 is buffered -> buffer unchanged; a subsequent read of 0x0010 is a hit with no mem_req.
- timeout=4, no ack on a read of word 5 -> bus_error pulses exactly once, 4 cycles after mem_req rises; mem_req drops; cpu_data_in=0xFFFF.
- reset=0 while in READ with mem_req high, then mem_ack arrives after reset release -> mem_req=0 at once; the stray ack is ignored; a fresh fetch of cpu_addr occurs.
